// File: rtl/lsb_mem_ctrl.sv
// Byte-serial memory responder for the load/store buffer and the instruction fetcher.
// One request at a time is spread over the 8-bit RAM/IO bus; loads and fetches finish with an extended result.
module lsb_mem_ctrl #(
    parameter int         ADDR_W = 32,
    parameter logic [1:0] IO_HI  = 2'b11
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              rdy_in,
    input  logic              clear_in,
    input  logic              io_buffer_full,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              lsb_req,
    input  logic [3:0]        lsb_type,
    input  logic [ADDR_W-1:0] lsb_addr,
    input  logic [31:0]       lsb_data,
    output logic              lsb_ready,
    output logic              lsb_done,
    output logic [31:0]       lsb_result,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic              if_done,
    output logic [31:0]       if_inst
);

    typedef enum logic [1:0] {IDLE, LOAD, STORE, FETCH} state_t;

    typedef struct packed {
        logic [2:0]        func3;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } req_t;

    state_t          state_q, state_d;
    req_t            req_q;
    logic [2:0]      step_q, step_nx, nb;
    logic [3:0][7:0] rbuf_q, nbuf;
    logic [1:0]      lane;
    logic [31:0]     ext;
    logic            wr_q, lsb_done_q, if_done_q;
    logic            rdy_q, finish, io_stall;
    logic [7:0]      din_save, din_eff;

    assign step_nx = step_q + 3'd1;
    assign lane    = step_q[1:0] - 2'd1;

    always_comb begin
        case (req_q.func3[1:0])
            2'b00:   nb = 3'd1;
            2'b01:   nb = 3'd2;
            default: nb = 3'd4;
        endcase
    end

    // The RAM keeps reading the held address while frozen, so the byte that was
    // valid in the first frozen cycle is kept and replayed on the resume cycle.
    assign din_eff = rdy_q ? mem_din : din_save;

    always_comb begin
        nbuf = rbuf_q;
        if (step_q >= 3'd1 && step_q <= nb)
            nbuf[lane] = din_eff;
    end

    always_comb begin
        case (req_q.func3)
            3'b000:  ext = {{24{nbuf[0][7]}}, nbuf[0]};
            3'b001:  ext = {{16{nbuf[1][7]}}, nbuf[1], nbuf[0]};
            3'b100:  ext = {24'b0, nbuf[0]};
            3'b101:  ext = {16'b0, nbuf[1], nbuf[0]};
            default: ext = nbuf;
        endcase
    end

    assign io_stall = (state_q == STORE) && (step_q < nb) &&
                      (mem_a[17:16] == IO_HI) && io_buffer_full;

    always_comb begin
        finish = 1'b0;
        case (state_q)
            LOAD, FETCH: finish = (step_q == nb + 3'd1);
            STORE:       finish = (step_q == nb);
            default:     finish = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (lsb_req)
                    state_d = lsb_type[3] ? STORE : LOAD;
                else if (if_req && !clear_in)
                    state_d = FETCH;
            end
            FETCH:   if (clear_in || finish) state_d = IDLE;
            default: if (finish) state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
        end else if (rdy_in) begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rdy_q    <= 1'b1;
            din_save <= 8'h00;
        end else begin
            rdy_q <= rdy_in;
            if (!rdy_in && rdy_q)
                din_save <= mem_din;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            req_q      <= '0;
            step_q     <= 3'd0;
            rbuf_q     <= '0;
            mem_a      <= '0;
            mem_dout   <= 8'h00;
            wr_q       <= 1'b0;
            lsb_done_q <= 1'b0;
            if_done_q  <= 1'b0;
            lsb_result <= 32'h0;
            if_inst    <= 32'h0;
        end else if (rdy_in) begin
            lsb_done_q <= 1'b0;
            if_done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    step_q <= 3'd0;
                    rbuf_q <= '0;
                    if (lsb_req) begin
                        req_q.func3 <= lsb_type[2:0];
                        req_q.addr  <= lsb_addr;
                        req_q.data  <= lsb_data;
                        mem_a       <= lsb_addr;
                        mem_dout    <= lsb_data[7:0];
                        wr_q        <= lsb_type[3];
                    end else if (if_req && !clear_in) begin
                        req_q.func3 <= 3'b010;
                        req_q.addr  <= if_addr;
                        mem_a       <= if_addr;
                        wr_q        <= 1'b0;
                    end
                end
                LOAD, FETCH: begin
                    if (!(state_q == FETCH && clear_in)) begin
                        step_q <= step_nx;
                        rbuf_q <= nbuf;
                        if (step_nx < nb)
                            mem_a <= req_q.addr + ADDR_W'(step_nx);
                        if (step_q == nb) begin
                            if (state_q == LOAD) begin
                                lsb_done_q <= 1'b1;
                                lsb_result <= ext;
                            end else begin
                                if_done_q <= 1'b1;
                                if_inst   <= nbuf;
                            end
                        end
                    end
                end
                STORE: begin
                    if (step_q < nb && !io_stall) begin
                        step_q <= step_nx;
                        if (step_nx < nb) begin
                            mem_a    <= req_q.addr + ADDR_W'(step_nx);
                            mem_dout <= req_q.data[{step_nx[1:0], 3'b000} +: 8];
                        end else begin
                            wr_q       <= 1'b0;
                            lsb_done_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_wr    = wr_q & rdy_in & ~io_stall;
    assign lsb_done  = lsb_done_q & rdy_in;
    assign if_done   = if_done_q & rdy_in;
    assign lsb_ready = (state_q == IDLE);
    assign if_ready  = (state_q == IDLE);

endmodule

// File: doc/lsb_mem_ctrl.md
Name: lsb_mem_ctrl

Overview:
- Memory-side responder for the load/store buffer and the instruction fetcher.
- Accepts one word/half/byte load or store request at a time from the LSB, plus instruction-word fetches from the IF stage.
- Serialises each request onto the 8-bit synchronous RAM/IO bus and returns a sign/zero-extended load result or store completion.
- Sits between the LSB/IF units and the top-level RAM port.

Parameters:
- ADDR_W, 32, byte-address width on the RAM and request sides.
- IO_HI, 2'b11, value of addr[17:16] that marks the IO region (writes stall on io_buffer_full).

Ports:
- clk_in  in  1  system clock.
- rst_n_in  in  1  reset, asynchronous, active-low.
- rdy_in  in  1  global ready; low freezes the block.
- clear_in  in  1  pipeline flush (branch mispredict).
- io_buffer_full  in  1  UART buffer full.
- mem_din  in  8  RAM read byte (valid one cycle after address).
- mem_dout  out  8  RAM write byte.
- mem_a  out  ADDR_W  RAM byte address.
- mem_wr  out  1  1 = write, 0 = read.
- lsb_req  in  1  LSB request valid.
- lsb_type  in  4  {is_write, func3}.
- lsb_addr  in  ADDR_W  effective address.
- lsb_data  in  32  store data.
- lsb_ready  out  1  block can accept LSB request this cycle.
- lsb_done  out  1  one-cycle completion pulse.
- lsb_result  out  32  extended load data.
- if_req  in  1  fetch request valid.
- if_addr  in  ADDR_W  fetch PC.
- if_ready  out  1  block can accept fetch this cycle.
- if_done  out  1  one-cycle fetch completion pulse.
- if_inst  out  32  fetched word.

Behaviour:
- Reset (rst_n_in low, async): state IDLE; mem_a=0, mem_dout=0, mem_wr=0, lsb_done=0, if_done=0, lsb_result=0, if_inst=0.
- rdy_in low: all registers hold, done pulses hold low, mem_wr forced 0.
- States: IDLE, LOAD, STORE, FETCH.
- IDLE arbitration:
  - lsb_req wins over if_req.
  - lsb_ready = if_ready = (state==IDLE).
  - An if_req not taken stays pending at the IF side; the block keeps no queue.
- Accept latches the request.
  - Byte count N by func3[1:0]: 00 -> 1, 01 -> 2, 10 -> 4; FETCH always 4.
  - func3[2] selects zero-extension for loads.
- LOAD/FETCH timing:
  - Byte k address (addr+k) is driven in cycle k+1 after the accept edge, k=0..N-1.
  - mem_din is captured one cycle later into byte lane k, little-endian.
  - Done pulses in cycle N+2 after accept, with result valid in the same cycle.
  - Result is extended to 32 bits per func3: LB/LH sign-extend, LBU/LHU zero-extend, LW raw.
- STORE timing:
  - Byte k of lsb_data (little-endian) is written with mem_wr=1 at addr+k in cycle k+1.
  - lsb_done pulses in cycle N+1.
  - If addr[17:16]==IO_HI and io_buffer_full=1, the byte is not issued; mem_wr=0 and the byte counter holds until io_buffer_full=0.
- After done, state returns to IDLE; the next request is accepted no earlier than the done cycle+1.
- Idle bus: mem_wr=0; mem_a holds its last value.
- clear_in:
  - Aborts FETCH immediately: state -> IDLE next cycle, no if_done.
  - LOAD/STORE are not aborted; the LSB owns flush of its own entries.
  - clear_in with if_req in IDLE: the fetch is not accepted.
- Address arithmetic is ADDR_W-bit wrap-around (0xFFFFFFFF+1 -> 0).
- lsb_req held high after acceptance while not ready is ignored; a new acceptance occurs only in IDLE.

Test Plan:
- Reset then LW at 0x100, RAM bytes 0x11,0x22,0x33,0x44 -> mem_a 0x100..0x103 on cycles 1-4; lsb_done in cycle 6, lsb_result=0x44332211.
- LB at 0x200 holding 0x80 -> lsb_result=0xFFFFFF80. LBU at the same address -> lsb_result=0x00000080. LH of 0x8001 -> 0xFFFF8001.
- SH data 0xDEADBEEF at 0x300 -> writes 0xEF@0x300 then 0xBE@0x301, mem_wr high 2 cycles; lsb_done in cycle 3; 0x302 untouched.
- SB to 0x30000 with io_buffer_full high 3 cycles -> mem_wr stays 0 for those cycles; byte written on first cycle it is low; lsb_done the cycle after.
- lsb_req and if_req together in IDLE -> LSB served first; if_ready low until its done; fetch then completes with if_inst correct.
- FETCH in progress with clear_in at cycle 2 -> no if_done; IDLE next cycle; new if_req accepted. rdy_in low mid-LW for 5 cycles -> result identical, latency +5.
